vram_arbiter: RTL and testbench



---
 rtl/vram_pkg.sv | 18 +
 rtl/vram_arbiter.sv | 141 ++++++++++++++
 tb/tb_vram_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared types and constants for the VRAM arbiter
//
// Purpose: FSM state encoding and default VRAM geometry used by vram_arbiter.
// Ports:   none (package).

package vram_pkg;

    localparam int VRAM_AW = 16;
    localparam int VRAM_DW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        RDATA = 2'd2,
        ACK   = 2'd3
    } vram_state_t;

endpackage

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM sharing between video scanout and CPU
//
// Purpose: video fetch owns the RAM whenever it requests; one CPU access at a
//          time is latched and issued in the first cycle video leaves free.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   vid_req, vid_a        video request and address for this cycle
//   vid_q                 video read data (RAM output passthrough)
//   cpu_req, cpu_we       CPU request (sampled in IDLE) and write select
//   cpu_a, cpu_d          CPU address and write data
//   cpu_q                 CPU read data, registered, held until next read
//   cpu_ready             one-cycle completion pulse
//   cpu_starve            pending CPU op has waited WAIT_LIMIT cycles
//   ram_a, ram_d, ram_we  RAM macro address / write data / write enable
//   ram_q                 RAM read data, valid the cycle after the address

module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AW         = VRAM_AW,
    parameter int DW         = VRAM_DW,
    parameter int WAIT_LIMIT = 255
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_a,
    output logic [DW-1:0] vid_q,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_a,
    input  logic [DW-1:0] cpu_d,
    output logic [DW-1:0] cpu_q,
    output logic          cpu_ready,
    output logic          cpu_starve,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q
);

    localparam int            CW    = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

    vram_state_t   state_q, state_d;
    logic [AW-1:0] lat_a_q, lat_a_d;
    logic [DW-1:0] lat_d_q, lat_d_d;
    logic          lat_we_q, lat_we_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] cpu_q_q, cpu_q_d;
    logic          ready_q, ready_d;
    logic          starve_q, starve_d;

    // CPU op is issued exactly when it is pending and video leaves the cycle free.
    logic cpu_issue;
    assign cpu_issue = (state_q == PEND) && !vid_req;

    always_comb begin
        state_d  = state_q;
        lat_a_d  = lat_a_q;
        lat_d_d  = lat_d_q;
        lat_we_d = lat_we_q;
        cnt_d    = cnt_q;
        cpu_q_d  = cpu_q_q;

        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    lat_a_d  = cpu_a;
                    lat_d_d  = cpu_d;
                    lat_we_d = cpu_we;
                    state_d  = PEND;
                end
            end
            PEND: begin
                if (vid_req) begin
                    if (cnt_q != LIMIT) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = lat_we_q ? ACK : RDATA;
                end
            end
            RDATA: begin
                // ram_q belongs to the CPU address issued last cycle, even if
                // video has already taken the RAM again this cycle.
                cpu_q_d = ram_q;
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d  = (state_d == ACK);
        starve_d = (state_d == PEND) && (cnt_d == LIMIT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            lat_a_q  <= '0;
            lat_d_q  <= '0;
            lat_we_q <= 1'b0;
            cnt_q    <= '0;
            cpu_q_q  <= '0;
            ready_q  <= 1'b0;
            starve_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lat_a_q  <= lat_a_d;
            lat_d_q  <= lat_d_d;
            lat_we_q <= lat_we_d;
            cnt_q    <= cnt_d;
            cpu_q_q  <= cpu_q_d;
            ready_q  <= ready_d;
            starve_q <= starve_d;
        end
    end

    // Grant mux: video address by default, latched CPU op only when issued.
    always_comb begin
        ram_a  = vid_a;
        ram_d  = lat_d_q;
        ram_we = 1'b0;
        if (cpu_issue) begin
            ram_a  = lat_a_q;
            ram_we = lat_we_q && !reset;
        end
    end

    assign vid_q      = ram_q;
    assign cpu_q      = cpu_q_q;
    assign cpu_ready  = ready_q;
    assign cpu_starve = starve_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - scoreboard bench for vram_arbiter

module tb_vram_arbiter;

    logic        clock;
    logic        reset;
    logic        vid_req;
    logic [15:0] vid_a;
    logic [7:0]  vid_q;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_d;
    logic [7:0]  cpu_q;
    logic        cpu_ready;
    logic        cpu_starve;
    logic [15:0] ram_a;
    logic [7:0]  ram_d;
    logic        ram_we;
    logic [7:0]  ram_q;

    logic [7:0]  vid_q4;
    logic [7:0]  cpu_q4;
    logic        cpu_ready4;
    logic        cpu_starve4;
    logic [15:0] ram_a4;
    logic [7:0]  ram_d4;
    logic        ram_we4;

    vram_arbiter #(.AW(16), .DW(8), .WAIT_LIMIT(255)) dut (
        .clock(clock), .reset(reset),
        .vid_req(vid_req), .vid_a(vid_a), .vid_q(vid_q),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .cpu_q(cpu_q), .cpu_ready(cpu_ready), .cpu_starve(cpu_starve),
        .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
    );

    vram_arbiter #(.AW(16), .DW(8), .WAIT_LIMIT(4)) dut4 (
        .clock(clock), .reset(reset),
        .vid_req(vid_req), .vid_a(vid_a), .vid_q(vid_q4),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .cpu_q(cpu_q4), .cpu_ready(cpu_ready4), .cpu_starve(cpu_starve4),
        .ram_a(ram_a4), .ram_d(ram_d4), .ram_we(ram_we4), .ram_q(ram_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [7:0] mem [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
        ram_q = 8'h00;
    end
    always @(posedge clock) begin
        if (ram_we) mem[ram_a] <= ram_d;
        ram_q <= mem[ram_a];
    end

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    typedef struct {
        int          cyc;
        logic [15:0] a;
        logic [7:0]  d;
    } exp_t;

    exp_t wr_sb[$];
    exp_t rdy_sb[$];
    exp_t vid_sb[$];

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic exp_starve4 = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event with no expectation (cycle %0d)", name, cyc);
    endtask

    function automatic exp_t mk(input int c, input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        e.cyc = c; e.a = a; e.d = d;
        return e;
    endfunction

    // Monitor: compares whatever the DUT presents against the scoreboards.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            chk("we_in_reset", 32'(ram_we), 32'd0);
        end else begin
            if (ram_we) begin
                if (wr_sb.size() == 0) fail_evt("ram_write");
                else begin
                    e = wr_sb.pop_front();
                    chk("wr_cycle", 32'(cyc), 32'(e.cyc));
                    chk("wr_addr", 32'(ram_a), 32'(e.a));
                    chk("wr_data", 32'(ram_d), 32'(e.d));
                end
            end
            if (cpu_ready) begin
                if (rdy_sb.size() == 0) fail_evt("cpu_ready");
                else begin
                    e = rdy_sb.pop_front();
                    chk("rdy_cycle", 32'(cyc), 32'(e.cyc));
                    chk("rdy_cpu_q", 32'(cpu_q), 32'(e.d));
                end
            end
            if (vid_req) begin
                chk("vid_grant_addr", 32'(ram_a), 32'(vid_a));
            end
            while (vid_sb.size() != 0 && vid_sb[0].cyc <= cyc) begin
                e = vid_sb.pop_front();
                chk("vid_cycle", 32'(cyc), 32'(e.cyc));
                chk("vid_q", 32'(vid_q), 32'(e.d));
            end
        end
        chk("starve_limit4", 32'(cpu_starve4), 32'(exp_starve4));
        chk("starve_limit255", 32'(cpu_starve), 32'd0);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a CPU request in the current cycle, then scramble the CPU inputs
    // so only the latched copy can produce the expected result.
    task automatic req(input logic we, input logic [15:0] a, input logic [7:0] d);
        cpu_req = 1'b1; cpu_we = we; cpu_a = a; cpu_d = d;
        tick();
        cpu_req = 1'b0; cpu_we = ~we; cpu_a = 16'hDEAD; cpu_d = 8'hFF;
    endtask

    initial begin
        int n;
        reset = 1'b1; vid_req = 1'b0; vid_a = 16'h0000;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = 16'h0000; cpu_d = 8'h00;
        repeat (3) tick();
        @(negedge clock);
        chk("reset_ready", 32'(cpu_ready), 32'd0);
        chk("reset_cpu_q", 32'(cpu_q), 32'd0);
        tick();
        reset = 1'b0;
        repeat (2) tick();

        // Uncontended write, then read back, then a write that must not touch cpu_q.
        n = cyc;
        wr_sb.push_back(mk(n + 1, 16'h8000, 8'h5A));
        rdy_sb.push_back(mk(n + 2, 16'h0, 8'h00));
        req(1'b1, 16'h8000, 8'h5A);
        repeat (3) tick();

        n = cyc;
        rdy_sb.push_back(mk(n + 3, 16'h0, 8'h5A));
        req(1'b0, 16'h8000, 8'h00);
        repeat (4) tick();

        n = cyc;
        wr_sb.push_back(mk(n + 1, 16'h8001, 8'h33));
        rdy_sb.push_back(mk(n + 2, 16'h0, 8'h5A));
        req(1'b1, 16'h8001, 8'h33);
        repeat (3) tick();

        // Write held off by 10 video cycles; starve flag on the WAIT_LIMIT=4 copy.
        n = cyc;
        wr_sb.push_back(mk(n + 11, 16'h8002, 8'hC3));
        rdy_sb.push_back(mk(n + 12, 16'h0, 8'h5A));
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 16'h8002; cpu_d = 8'hC3;
        for (int i = 1; i <= 10; i++) begin
            tick();
            cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = 16'hBEEF; cpu_d = 8'h00;
            vid_req = 1'b1;
            vid_a = 16'h1000 + 16'(i);
            vid_sb.push_back(mk(n + i + 1, vid_a, pat(vid_a)));
            exp_starve4 = (i >= 5);
        end
        tick();
        vid_req = 1'b0;
        exp_starve4 = 1'b1;
        tick();
        exp_starve4 = 1'b0;
        repeat (2) tick();

        // CPU read interleaved with video reads toggling every cycle.
        n = cyc;
        rdy_sb.push_back(mk(n + 4, 16'h0, 8'hC3));
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 16'h8002; cpu_d = 8'h00;
        for (int i = 1; i <= 6; i++) begin
            tick();
            cpu_req = 1'b0; cpu_we = 1'b1; cpu_a = 16'hBEEF; cpu_d = 8'hAA;
            vid_req = (i % 2 == 1);
            vid_a = 16'h2000 + 16'(i);
            if (vid_req) vid_sb.push_back(mk(n + i + 1, vid_a, pat(vid_a)));
        end
        tick();
        vid_req = 1'b0;
        repeat (2) tick();

        // Reset while PEND with video idle: the write must never reach the RAM.
        req(1'b1, 16'h9000, 8'h77);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("pend_reset_cpu_q", 32'(cpu_q), 32'd0);
        chk("pend_reset_ready", 32'(cpu_ready), 32'd0);
        n = cyc;
        rdy_sb.push_back(mk(n + 3, 16'h0, 8'h90));
        req(1'b0, 16'h9000, 8'h00);
        repeat (4) tick();

        // Reset while RDATA: no ready, cpu_q cleared, next request accepted at once.
        req(1'b0, 16'h8000, 8'h00);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("rdata_reset_cpu_q", 32'(cpu_q), 32'd0);
        n = cyc;
        wr_sb.push_back(mk(n + 1, 16'h8003, 8'hE1));
        rdy_sb.push_back(mk(n + 2, 16'h0, 8'h00));
        req(1'b1, 16'h8003, 8'hE1);
        repeat (3) tick();

        n = cyc;
        rdy_sb.push_back(mk(n + 3, 16'h0, 8'hE1));
        req(1'b0, 16'h8003, 8'h00);
        repeat (6) tick();

        chk("wr_sb_drained", 32'(wr_sb.size()), 32'd0);
        chk("rdy_sb_drained", 32'(rdy_sb.size()), 32'd0);
        chk("vid_sb_drained", 32'(vid_sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
